lce_probe_tracer: RTL and testbench
===================================

LCE_PROBE_TRACER -- requirements
Module: lce_probe_tracer

Interface
REQ-001 SHALL have parameter N_PROBES, default 32, probe bus width; legal values are multiples of 8 in the range 8..64.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, capture FIFO entries; legal values are powers of 2 in the range 4..256.
REQ-003 SHALL have parameter CLKS_PER_BIT, default 868, UART bit period in clk_i cycles (100 MHz / 115200); legal values are >= 4.
REQ-004 SHALL have port clk_i, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit, the reset; reset is asynchronous and active-high.
REQ-006 SHALL have port enable_i, input, 1 bit, capture enable.
REQ-007 SHALL have port probes_i, input, N_PROBES bits, LCE probe vector from the core_v_mcu wrapper.
REQ-008 SHALL have port alarm_i, input, 1 bit, LCE alarm from the core_v_mcu wrapper.
REQ-009 SHALL have port clear_ovf_i, input, 1 bit, a one-cycle pulse that clears overflow_o.
REQ-010 SHALL have port uart_tx_o, output, 1 bit, 8N1 serial stream to the host.
REQ-011 SHALL have port busy_o, output, 1 bit, high when the FIFO is non-empty or the transmitter is not idle.
REQ-012 SHALL have port overflow_o, output, 1 bit, sticky flag for a dropped capture.

Function
REQ-013 SHALL register last_cap (N_PROBES bits) and alarm_q (1 bit) to hold the last captured probe value and the previous alarm_i.
REQ-014 SHALL raise a capture event in a cycle when enable_i=1 and either (probes_i != last_cap) or (alarm_i=1 and alarm_q=0).
REQ-015 SHALL, on a capture event, write {alarm_i, probes_i} into the FIFO and update last_cap at the same clock edge, provided the write is accepted.
REQ-016 SHALL accept a write when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-017 SHALL, when a write is refused, drop the sample, leave last_cap unchanged, and set overflow_o at that edge.
REQ-018 SHALL clear overflow_o on clear_ovf_i=1; if a set and a clear coincide, set wins.
REQ-019 SHALL hold all captures while enable_i=0, with last_cap and alarm_q still tracking normally.
REQ-020 SHALL use FIFO pointers of log2(FIFO_DEPTH)+1 bits that wrap modulo 2*FIFO_DEPTH; full when MSBs differ and LSBs are equal, empty when the pointers are equal.
REQ-021 SHALL send one frame per FIFO entry: a header byte 0xA5 (alarm=0) or 0x5A (alarm=1), then N_PROBES/8 probe bytes, least-significant byte first.
REQ-022 SHALL transmit each byte as UART 8N1: start bit 0, 8 data bits LSB first, stop bit 1, each bit exactly CLKS_PER_BIT cycles; the line idles at 1.
REQ-023 SHALL implement the frame FSM with states IDLE, LOAD, START, DATA, STOP.
REQ-024 SHALL move IDLE to LOAD when the FIFO is non-empty; LOAD pops one entry into the frame shift register, selects the header byte, and moves to START.
REQ-025 SHALL move START to DATA, DATA to STOP after 8 bits, and STOP to START while frame bytes remain, otherwise STOP to IDLE.
REQ-026 SHALL place no idle bit between consecutive frames: STOP goes to LOAD directly when the frame is complete and the FIFO is non-empty.
REQ-027 SHALL drive the start bit of a new frame on uart_tx_o no later than 2 clk_i cycles after a push into an empty FIFO while the FSM is IDLE.
REQ-028 SHALL make the pop occur only in LOAD; it is the only read path.

Reset
REQ-029 SHALL, with rst_i=1, immediately (asynchronously) force: uart_tx_o=1, busy_o=0, overflow_o=0, FSM=IDLE, FIFO empty, last_cap=0, alarm_q=0, bit and baud counters=0.
REQ-030 SHALL abandon any frame in progress on reset, with no further bits sent, and resume normal behaviour on the first clk_i edge after rst_i falls.

Verification
REQ-031 Single change: N_PROBES=32, enable_i=1, probes_i goes 0 -> 0x12345678 -> uart_tx_o emits A5 78 56 34 12 (50 bit periods), then idles high; busy_o=0 afterwards.
REQ-032 Alarm edge: alarm_i 0 -> 1 with probes_i unchanged -> exactly one frame, header 0x5A; holding alarm_i=1 produces no further frames.
REQ-033 Overflow: FIFO_DEPTH=4, 6 distinct probe values on consecutive cycles -> first frame's entry popped, 4 frames queued, 1 dropped -> overflow_o=1 and 5 frames sent in total; clear_ovf_i pulse -> overflow_o=0.
REQ-034 Full with pop: force a write on the exact LOAD cycle while the FIFO is full -> write accepted, overflow_o stays 0.
REQ-035 Reset mid-frame: assert rst_i during the DATA bit 3 of byte 2 -> uart_tx_o=1 within the same cycle, with no remaining bits sent, FIFO empty, and the next change produces a clean full frame.
REQ-036 Enable gating: enable_i=0 while probes_i toggles 10 times -> no frames; set enable_i=1 with probes_i stable and != last_cap -> exactly one frame.

Source files
------------

// File: rtl/lce_probe_tracer.sv
// lce_probe_tracer: captures changes of the LCE probe vector (and rising edges
// of the LCE alarm) into a small FIFO and streams each capture to a host as a
// UART 8N1 frame: header byte (0xA5 normal, 0x5A alarm) then the probe bytes,
// least-significant byte first.
//
// Ports:
//   clk_i        single clock, rising edge
//   rst_i        asynchronous active-high reset
//   enable_i     capture enable
//   probes_i     LCE probe vector (N_PROBES bits)
//   alarm_i      LCE alarm
//   clear_ovf_i  one-cycle pulse clearing overflow_o
//   uart_tx_o    8N1 serial output, idles high
//   busy_o       FIFO non-empty or transmitter active
//   overflow_o   sticky flag: a capture was dropped because the FIFO was full
module lce_probe_tracer #(
    parameter int unsigned N_PROBES     = 32,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                enable_i,
    input  logic [N_PROBES-1:0] probes_i,
    input  logic                alarm_i,
    input  logic                clear_ovf_i,
    output logic                uart_tx_o,
    output logic                busy_o,
    output logic                overflow_o
);

    localparam int unsigned ENTRY_W    = N_PROBES + 1;
    localparam int unsigned AW         = $clog2(FIFO_DEPTH);
    localparam int unsigned PW         = AW + 1;
    localparam int unsigned NBYTES     = N_PROBES / 8;
    localparam int unsigned BYTE_CNT_W = 4;
    localparam int unsigned BAUD_W     = $clog2(CLKS_PER_BIT);
    localparam logic [7:0]  HDR_NORMAL = 8'hA5;
    localparam logic [7:0]  HDR_ALARM  = 8'h5A;

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

    state_t                  state;
    logic [ENTRY_W-1:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr, rd_ptr;
    logic [N_PROBES-1:0]     last_cap;
    logic                    alarm_q;
    logic [N_PROBES-1:0]     frame_q;
    logic [7:0]              cur_byte;
    logic [BYTE_CNT_W-1:0]   bytes_left;
    logic [2:0]              bit_cnt;
    logic [BAUD_W-1:0]       baud_cnt;

    logic                    fifo_empty, fifo_full, pop, push, cap_event, ovf_set;
    logic                    baud_end, baud_pre, frame_done, fsm_busy_nxt;
    logic [PW-1:0]           wr_ptr_nxt, rd_ptr_nxt;
    logic [ENTRY_W-1:0]      rd_data;

    // FIFO status, capture decision and next-cycle busy prediction
    always_comb begin
        fifo_empty   = (wr_ptr == rd_ptr);
        fifo_full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop          = (state == LOAD);
        cap_event    = enable_i && ((probes_i != last_cap) || (alarm_i && !alarm_q));
        push         = cap_event && (!fifo_full || pop);
        ovf_set      = cap_event && !push;
        wr_ptr_nxt   = wr_ptr + PW'(push);
        rd_ptr_nxt   = rd_ptr + PW'(pop);
        rd_data      = mem[rd_ptr[AW-1:0]];
        baud_end     = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
        baud_pre     = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 2));
        frame_done   = (state == STOP) && baud_end && (bytes_left == '0);
        fsm_busy_nxt = (state == IDLE) ? !fifo_empty : !frame_done;
    end

    // FIFO storage; no reset needed, validity is tracked by the pointers
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {alarm_i, probes_i};
        end
    end

    // Capture tracking, FIFO pointers and status flags
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            last_cap   <= '0;
            alarm_q    <= 1'b0;
            overflow_o <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr_nxt;
            rd_ptr  <= rd_ptr_nxt;
            alarm_q <= alarm_i;
            if (push) begin
                last_cap <= probes_i;
            end
            // a coinciding set beats the clear
            if (ovf_set) begin
                overflow_o <= 1'b1;
            end else if (clear_ovf_i) begin
                overflow_o <= 1'b0;
            end
            busy_o <= (wr_ptr_nxt != rd_ptr_nxt) || fsm_busy_nxt;
        end
    end

    // Frame/UART FSM. The stop bit of a frame's last byte hands over to LOAD one
    // cycle early when more data is queued, so LOAD fills the final stop-bit
    // cycle and back-to-back frames keep exact bit timing with no idle gap.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            uart_tx_o  <= 1'b1;
            frame_q    <= '0;
            cur_byte   <= '0;
            bytes_left <= '0;
            bit_cnt    <= '0;
            baud_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    uart_tx_o <= 1'b1;
                    baud_cnt  <= '0;
                    if (!fifo_empty) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    frame_q    <= rd_data[N_PROBES-1:0];
                    cur_byte   <= rd_data[N_PROBES] ? HDR_ALARM : HDR_NORMAL;
                    bytes_left <= BYTE_CNT_W'(NBYTES);
                    uart_tx_o  <= 1'b0;
                    baud_cnt   <= '0;
                    state      <= START;
                end
                START: begin
                    if (baud_end) begin
                        baud_cnt  <= '0;
                        uart_tx_o <= cur_byte[0];
                        cur_byte  <= cur_byte >> 1;
                        bit_cnt   <= '0;
                        state     <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            uart_tx_o <= 1'b1;
                            state     <= STOP;
                        end else begin
                            uart_tx_o <= cur_byte[0];
                            cur_byte  <= cur_byte >> 1;
                            bit_cnt   <= bit_cnt + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (bytes_left != '0 && baud_end) begin
                        cur_byte   <= frame_q[7:0];
                        frame_q    <= frame_q >> 8;
                        bytes_left <= bytes_left - BYTE_CNT_W'(1);
                        uart_tx_o  <= 1'b0;
                        baud_cnt   <= '0;
                        state      <= START;
                    end else if (bytes_left == '0 && baud_pre && !fifo_empty) begin
                        baud_cnt <= '0;
                        state    <= LOAD;
                    end else if (bytes_left == '0 && baud_end) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                default: begin
                    uart_tx_o <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lce_probe_tracer.sv
// Testbench for lce_probe_tracer: directed stimulus pushes expected frames into
// a scoreboard queue; a UART receiver process decodes uart_tx_o and compares
// every received frame against the head of the queue.
module tb_lce_probe_tracer;

    localparam int unsigned N_PROBES   = 32;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned CLKS       = 8;
    localparam int unsigned NB         = N_PROBES / 8;
    localparam int unsigned FRAME_CYC  = 10 * (NB + 1) * CLKS;

    logic                clk = 1'b0;
    logic                rst;
    logic                enable;
    logic [N_PROBES-1:0] probes;
    logic                alarm;
    logic                clear_ovf;
    logic                tx;
    logic                busy;
    logic                ovf;

    int                  n_tests   = 0;
    int                  n_fail    = 0;
    int                  rst_epoch = 0;
    int                  mon_idx   = 0;
    logic [N_PROBES:0]   sb [$];

    always #5 clk = ~clk;

    lce_probe_tracer #(
        .N_PROBES     (N_PROBES),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .CLKS_PER_BIT (CLKS)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .enable_i    (enable),
        .probes_i    (probes),
        .alarm_i     (alarm),
        .clear_ovf_i (clear_ovf),
        .uart_tx_o   (tx),
        .busy_o      (busy),
        .overflow_o  (ovf)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_frame(input logic a, input logic [N_PROBES-1:0] p);
        sb.push_back({a, p});
    endtask

    // bounded wait until all expected frames are received and the DUT is idle
    task automatic drain(input int budget, input string name);
        int n;
        n = 0;
        while ((busy || sb.size() != 0 || mon_idx != 0) && n < budget) begin
            step();
            n++;
        end
        check(name, 64'({busy, 16'(sb.size())}), 64'd0);
    endtask

    // UART receiver + scoreboard compare
    initial begin : monitor
        logic [7:0]          b;
        logic [7:0]          fb [NB+1];
        logic [N_PROBES-1:0] got_p;
        logic [N_PROBES:0]   exp_e;
        logic [7:0]          exp_h;
        logic                start_b, stop_b;
        int                  e0;
        int                  frame_epoch;
        frame_epoch = 0;
        b = '0;
        forever begin
            @(negedge tx);
            e0 = rst_epoch;
            repeat (CLKS / 2) @(negedge clk);
            start_b = tx;
            for (int i = 0; i < 8; i++) begin
                repeat (CLKS) @(negedge clk);
                b[i] = tx;
            end
            repeat (CLKS) @(negedge clk);
            stop_b = tx;
            if (rst_epoch != e0 || rst) begin
                mon_idx = 0;
            end else begin
                check("uart start/stop bits", 64'({start_b, stop_b}), 64'd1);
                if (mon_idx != 0 && frame_epoch != e0) mon_idx = 0;
                frame_epoch = e0;
                fb[mon_idx] = b;
                mon_idx++;
                if (mon_idx == NB + 1) begin
                    mon_idx = 0;
                    for (int k = 0; k < NB; k++) got_p[k*8 +: 8] = fb[k+1];
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected frame: got %h %h, expected none", fb[0], got_p);
                    end else begin
                        exp_e = sb.pop_front();
                        exp_h = exp_e[N_PROBES] ? 8'h5A : 8'hA5;
                        check("frame header", 64'(fb[0]), 64'(exp_h));
                        check("frame payload", 64'(got_p), 64'(exp_e[N_PROBES-1:0]));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin : stimulus
        int quiet_err;
        rst       = 1'b1;
        enable    = 1'b1;
        probes    = '0;
        alarm     = 1'b0;
        clear_ovf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset tx", 64'(tx), 64'd1);
        check("reset busy", 64'(busy), 64'd0);
        check("reset overflow", 64'(ovf), 64'd0);
        rst = 1'b0;
        step();

        // single change: A5 78 56 34 12, 50 bit periods
        probes = 32'h1234_5678;
        expect_frame(1'b0, 32'h1234_5678);
        step();
        check("busy after push", 64'(busy), 64'd1);
        check("line idle before start", 64'(tx), 64'd1);
        step();
        check("line idle in load", 64'(tx), 64'd1);
        step();
        check("start bit 2 cycles after push", 64'(tx), 64'd0);
        repeat (FRAME_CYC - 1) step();
        check("busy at last frame cycle", 64'(busy), 64'd1);
        step();
        check("busy clear after 50 bits", 64'(busy), 64'd0);
        check("line idle after frame", 64'(tx), 64'd1);
        drain(200, "single change drained");

        // alarm rising edge: exactly one 0x5A frame while alarm held
        alarm = 1'b1;
        expect_frame(1'b1, 32'h1234_5678);
        step();
        drain(1000, "alarm frame drained");
        repeat (300) step();
        check("alarm held no further frames", 64'(busy), 64'd0);
        alarm = 1'b0;
        step();

        // enable gating
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            probes = 32'hA000_0000 + 32'(i);
            step();
        end
        repeat (20) step();
        check("disabled no frames", 64'(busy), 64'd0);
        probes = 32'hDEAD_BEEF;
        repeat (2) step();
        enable = 1'b1;
        expect_frame(1'b0, 32'hDEAD_BEEF);
        step();
        drain(1000, "enable frame drained");
        repeat (50) step();
        check("enable single frame", 64'(busy), 64'd0);

        // overflow: 6 values back to back, the 6th is dropped
        for (int k = 1; k <= 6; k++) begin
            probes = 32'h1111_1111 * 32'(k);
            if (k <= 5) expect_frame(1'b0, 32'h1111_1111 * 32'(k));
            step();
            if (k == 5) check("full write no overflow", 64'(ovf), 64'd0);
        end
        check("overflow set on drop", 64'(ovf), 64'd1);
        probes = 32'h5555_5555;
        drain(3000, "overflow frames drained");
        check("overflow sticky", 64'(ovf), 64'd1);
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        check("overflow cleared", 64'(ovf), 64'd0);

        // full FIFO with a write on the LOAD (pop) cycle
        for (int k = 1; k <= 5; k++) begin
            probes = 32'h2000_0000 + 32'(k);
            expect_frame(1'b0, 32'h2000_0000 + 32'(k));
            step();
        end
        repeat (2 + FRAME_CYC - 5) step();
        probes = 32'h3333_3333;
        expect_frame(1'b0, 32'h3333_3333);
        step();
        check("write on pop cycle accepted", 64'(ovf), 64'd0);
        drain(3500, "full-with-pop frames drained");
        check("no overflow after full-with-pop", 64'(ovf), 64'd0);

        // reset during data bit 3 of byte 2
        probes = 32'h1234_5678;
        expect_frame(1'b0, 32'h1234_5678);
        repeat (3) step();
        repeat (24 * CLKS + CLKS / 2 - 1) step();
        check("data bit before reset", 64'(tx), 64'd0);
        rst = 1'b1;
        rst_epoch++;
        sb.delete();
        probes = '0;
        #1;
        check("async reset tx high", 64'(tx), 64'd1);
        check("async reset busy low", 64'(busy), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        quiet_err = 0;
        for (int i = 0; i < 150; i++) begin
            step();
            if (tx !== 1'b1 || busy !== 1'b0) quiet_err++;
        end
        check("no bits after reset", 64'(quiet_err), 64'd0);
        probes = 32'h0F0F_0F0F;
        expect_frame(1'b0, 32'h0F0F_0F0F);
        step();
        drain(1000, "post-reset frame drained");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
